fin_test_gen: RTL

FIN_TEST_GEN -- requirements
Module: fin_test_gen

---
 rtl/fin_test_gen_pkg.sv | 14 +
 rtl/fin_test_chan.sv | 73 +++++++
 rtl/fin_test_gen.sv | 73 +++++++
 3 files changed

// File: rtl/fin_test_gen_pkg.sv
// Shared definitions for the test-signal generator: config-word field offsets
// and the config-word width helper.
package fin_test_gen_pkg;

    // Flag positions are offsets above the DIV_W-bit N field
    localparam int EN_OFS    = 0;
    localparam int INV_OFS   = 1;
    localparam int PULSE_OFS = 2;

    function automatic int cfg_width(input int div_w);
        return div_w + 3;
    endfunction

endpackage

// File: rtl/fin_test_chan.sv
// One test-signal channel: config register, down-counter, phase bit and the
// registered output (phase XOR INV).
module fin_test_chan
    import fin_test_gen_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_i,
    input  logic                          sync_i,
    input  logic [cfg_width(DIV_W)-1:0]   data_i,
    output logic [cfg_width(DIV_W)-1:0]   cfg_o,
    output logic                          fin_o
);

    localparam int CW = cfg_width(DIV_W);

    logic [CW-1:0]    cfg_q, cfg_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             fin_q, fin_d;

    logic [DIV_W-1:0] n_cur;
    logic             en, inv, pulse;

    assign n_cur = cfg_q[DIV_W-1:0];
    assign en    = cfg_q[DIV_W+EN_OFS];
    assign inv   = cfg_q[DIV_W+INV_OFS];
    assign pulse = cfg_q[DIV_W+PULSE_OFS];

    // A write beats sync, sync beats counting; a disabled channel sits at N with phase 0
    always_comb begin
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        fin_d   = phase_q ^ inv;
        if (wr_i) begin
            cfg_d   = data_i;
            cnt_d   = data_i[DIV_W-1:0];
            phase_d = 1'b0;
        end else if (sync_i || !en) begin
            cnt_d   = n_cur;
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = n_cur;
            phase_d = pulse ? 1'b1 : ~phase_q;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
            if (pulse) begin
                phase_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            fin_q   <= fin_d;
        end
    end

    assign cfg_o = cfg_q;
    assign fin_o = fin_q;

endmodule

// File: rtl/fin_test_gen.sv
// Multi-channel square/pulse test-signal generator with per-channel config
// writes, registered readback and a global phase-restart input.
module fin_test_gen
    import fin_test_gen_pkg::*;
#(
    parameter int CHANNELS = 24,
    parameter int DIV_W    = 16,
    parameter int ADDR_W   = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_i,
    input  logic                          rd_i,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [cfg_width(DIV_W)-1:0]   data_i,
    input  logic                          sync_i,
    output logic [cfg_width(DIV_W)-1:0]   rdata_o,
    output logic                          rvalid_o,
    output logic [CHANNELS-1:0]           fin_o
);

    localparam int CW = cfg_width(DIV_W);

    logic [CW-1:0] cfg_all [CHANNELS];
    logic [CW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    // Addresses at or above CHANNELS match no channel, so such writes vanish
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic wr_sel;
        assign wr_sel = wr_i && (addr_i == ADDR_W'(i));

        fin_test_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .wr_i   (wr_sel),
            .sync_i (sync_i),
            .data_i (data_i),
            .cfg_o  (cfg_all[i]),
            .fin_o  (fin_o[i])
        );
    end

    // Readback samples the pre-write config and holds between reads
    always_comb begin
        rvalid_d = rd_i;
        rdata_d  = rdata_q;
        if (rd_i) begin
            rdata_d = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (addr_i == ADDR_W'(i)) begin
                    rdata_d = cfg_all[i];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule
